signal_creater_ctrl: RTL and testbench

- Burst controller for the 4-bit nonlinear-feedback signal generator.
- Loads a seed and runs the generator for a programmed number of bits.
- Streams each bit with a valid strobe and packs the bits MSB-first into WORD_W-bit words.
- Provides start/busy/done handshake, abort, and a sticky stuck-at-zero error flag.

---
 rtl/signal_creater_ctrl_pkg.sv | 29 ++
 rtl/signal_creater_ctrl_core.sv | 44 ++++
 rtl/signal_creater_ctrl.sv | 173 +++++++++++++++++
 tb/tb_signal_creater_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/signal_creater_ctrl_pkg.sv
// Shared definitions for the signal_creater_ctrl burst controller.
//   - state_e      : controller FSM encoding
//   - SIG_W        : width of the nonlinear-feedback generator state
//   - FB_*         : generator states whose feedback bit is 1
//   - fb_of()      : feedback function of the generator
package signal_creater_ctrl_pkg;

  localparam int SIG_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [SIG_W-1:0] FB_A = 4'b1001;
  localparam logic [SIG_W-1:0] FB_B = 4'b0011;
  localparam logic [SIG_W-1:0] FB_C = 4'b0111;
  localparam logic [SIG_W-1:0] FB_D = 4'b1100;

  // Feedback is 1 only for the four listed states; 0000 therefore maps to
  // itself and is a fixed point of the generator.
  function automatic logic fb_of(input logic [SIG_W-1:0] s);
    return (s == FB_A) || (s == FB_B) || (s == FB_C) || (s == FB_D);
  endfunction

endpackage

// File: rtl/signal_creater_ctrl_core.sv
// signal_core: 4-bit nonlinear-feedback generator.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset (state -> 0000)
//   load     in   load seed into the state (has priority over shift_en)
//   shift_en in   advance the generator one step
//   seed     in   value loaded on load
//   state    out  current generator state
//   out      out  current output bit (state MSB)
module signal_core
  import signal_creater_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [SIG_W-1:0] seed,
  output logic [SIG_W-1:0] state,
  output logic             out
);

  logic [SIG_W-1:0] s_q, s_d;

  always_comb begin
    s_d = s_q;
    if (load) begin
      s_d = seed;
    end else if (shift_en) begin
      s_d = {s_q[SIG_W-2:0], fb_of(s_q)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign state = s_q;
  assign out   = s_q[SIG_W-1];

endmodule

// File: rtl/signal_creater_ctrl.sv
// signal_creater_ctrl: burst controller for the 4-bit nonlinear-feedback
// generator. Loads a seed, runs the generator for len bits, streams each bit
// with a valid strobe and packs the bits MSB-first into WORD_W-bit words.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, seed, len  burst request; seed/len captured when start accepted
//   abort             cancel an active burst (no done, partial word dropped)
//   bit_out/bit_valid generator bit and burst-bit strobe
//   word_out/word_valid packed word and its one-cycle strobe
//   busy, done        handshake: busy outside IDLE, done pulse on completion
//   err_stuck         sticky: generator state was 0000 during RUN
module signal_creater_ctrl
  import signal_creater_ctrl_pkg::*;
#(
  parameter int LEN_W  = 8,
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SIG_W-1:0]  seed,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              busy,
  output logic              done,
  output logic              err_stuck
);

  localparam int FILL_W = $clog2(WORD_W + 1);

  state_e            state_q, state_d;
  logic [SIG_W-1:0]  seed_q, seed_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              wv_q, wv_d;
  logic              err_q, err_d;

  logic              core_load;
  logic              core_shift;
  logic [SIG_W-1:0]  core_state;
  logic              core_out;

  // Partial word: the n collected bits sit at the LSBs of the shift
  // register; move them to the top and zero-fill below.
  function automatic logic [WORD_W-1:0] left_justify(
    input logic [WORD_W-1:0] bits,
    input logic [FILL_W-1:0] n
  );
    return bits << (WORD_W - int'(n));
  endfunction

  signal_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (core_load),
    .shift_en (core_shift),
    .seed     (seed_q),
    .state    (core_state),
    .out      (core_out)
  );

  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    sr_d       = sr_q;
    word_d     = word_q;
    wv_d       = 1'b0;
    err_d      = err_q;
    core_load  = 1'b0;
    core_shift = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          seed_d  = seed;
          len_d   = len;
          err_d   = 1'b0;
          state_d = (len != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        core_load = 1'b1;
        cnt_d     = '0;
        fill_d    = '0;
        sr_d      = '0;
        state_d   = RUN;
      end
      RUN: begin
        core_shift = 1'b1;
        sr_d       = {sr_q[WORD_W-2:0], core_out};
        cnt_d      = cnt_q + LEN_W'(1);
        if (core_state == '0) begin
          err_d = 1'b1;
        end
        if (fill_q == FILL_W'(WORD_W - 1)) begin
          word_d = sr_d;
          wv_d   = 1'b1;
          fill_d = '0;
        end else begin
          fill_d = fill_q + FILL_W'(1);
        end
        // len_q is never 0 here, so len_q-1 cannot wrap.
        if (cnt_q == len_q - LEN_W'(1)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (fill_q != '0) begin
          word_d = left_justify(sr_q, fill_q);
          wv_d   = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything except the sticky error flag: any word
    // completing on this edge is dropped.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      word_d  = word_q;
      wv_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seed_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      sr_q    <= '0;
      word_q  <= '0;
      wv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      wv_q    <= wv_d;
      err_q   <= err_d;
    end
  end

  assign bit_out    = core_out;
  assign bit_valid  = (state_q == RUN);
  assign word_out   = word_q;
  assign word_valid = wv_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE) && !abort;
  assign err_stuck  = err_q;

endmodule

// File: tb/tb_signal_creater_ctrl.sv
module tb_signal_creater_ctrl;

  localparam int LEN_W  = 8;
  localparam int WORD_W = 8;
  localparam int MAXC   = 300;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [3:0]        seed;
  logic [LEN_W-1:0]  len;
  logic              abort;
  logic              bit_out;
  logic              bit_valid;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              busy;
  logic              done;
  logic              err_stuck;

  int checks   = 0;
  int failures = 0;

  // Expected per-cycle view of one burst; cycle 0 is the cycle after the
  // edge that accepted start.
  int e_busy [MAXC];
  int e_bv   [MAXC];
  int e_bit  [MAXC];
  int e_wv   [MAXC];
  int e_word [MAXC];
  int e_done [MAXC];

  signal_creater_ctrl #(.LEN_W(LEN_W), .WORD_W(WORD_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed       (seed),
    .len        (len),
    .abort      (abort),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .busy       (busy),
    .done       (done),
    .err_stuck  (err_stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Generator rule: feedback 1 only for 1001, 0011, 0111, 1100.
  function automatic logic [3:0] gen_next(input logic [3:0] s);
    logic fb;
    fb = (s == 4'b1001) || (s == 4'b0011) || (s == 4'b0111) || (s == 4'b1100);
    return {s[2:0], fb};
  endfunction

  // ab = bit_valid cycle (1-based) in which abort is raised, 0 = none.
  // noise = toggle start/seed/len while busy (must be ignored).
  task automatic run_burst(input logic [3:0] sd, input int ln, input int ab, input bit noise);
    logic [3:0] s;
    int acc, n, stop, last, lastbusy;
    int e_err;
    for (int c = 0; c < MAXC; c++) begin
      e_busy[c] = 0; e_bv[c] = 0; e_bit[c] = 0;
      e_wv[c] = 0; e_word[c] = 0; e_done[c] = 0;
    end
    s = sd; acc = 0; n = 0; e_err = 0;
    if (ln == 0) begin
      last = 1;
      e_busy[0] = 1;
      e_done[0] = 1;
    end else begin
      stop     = (ab > 0) ? ab : ln;
      lastbusy = (ab > 0) ? ab : ln + 2;
      last     = (ab > 0) ? ab + 2 : ln + 3;
      for (int c = 0; c <= lastbusy; c++) e_busy[c] = 1;
      for (int i = 1; i <= stop; i++) begin
        e_bv[i]  = 1;
        e_bit[i] = int'(s[3]);
        if (s == 4'b0000) e_err = 1;
        acc = (acc << 1) | int'(s[3]);
        n++;
        s = gen_next(s);
        if (n == WORD_W) begin
          if (ab == 0 || i < ab) begin
            e_wv[i+1]   = 1;
            e_word[i+1] = acc;
          end
          acc = 0;
          n   = 0;
        end
      end
      if (ab == 0) begin
        if (n > 0) begin
          e_wv[ln+2]   = 1;
          e_word[ln+2] = acc << (WORD_W - n);
        end
        e_done[ln+2] = 1;
      end
    end

    @(negedge clk);
    start = 1'b1;
    seed  = sd;
    len   = LEN_W'(ln);
    abort = 1'b0;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      check($sformatf("busy s%0h l%0d c%0d", sd, ln, c), 32'(busy), e_busy[c]);
      check($sformatf("bit_valid s%0h l%0d c%0d", sd, ln, c), 32'(bit_valid), e_bv[c]);
      if (e_bv[c] != 0)
        check($sformatf("bit_out s%0h l%0d c%0d", sd, ln, c), 32'(bit_out), e_bit[c]);
      check($sformatf("word_valid s%0h l%0d c%0d", sd, ln, c), 32'(word_valid), e_wv[c]);
      if (e_wv[c] != 0)
        check($sformatf("word_out s%0h l%0d c%0d", sd, ln, c), 32'(word_out), e_word[c]);
      check($sformatf("done s%0h l%0d c%0d", sd, ln, c), 32'(done), e_done[c]);
      if (c == last)
        check($sformatf("err_stuck s%0h l%0d", sd, ln), 32'(err_stuck), e_err);
      start = 1'b0;
      abort = 1'b0;
      if (noise && e_busy[c] != 0) begin
        start = 1'($urandom_range(0, 1));
        seed  = 4'($urandom);
        len   = LEN_W'($urandom);
      end
      if (ab > 0 && c == ab) begin
        abort = 1'b1;
        start = 1'b1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int ln, ab;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    seed  = '0;
    len   = '0;
    repeat (2) @(negedge clk);
    check("rst busy", 32'(busy), 0);
    check("rst bit_valid", 32'(bit_valid), 0);
    check("rst bit_out", 32'(bit_out), 0);
    check("rst word_valid", 32'(word_valid), 0);
    check("rst word_out", 32'(word_out), 0);
    check("rst done", 32'(done), 0);
    check("rst err_stuck", 32'(err_stuck), 0);
    rst_n = 1'b1;

    // Directed cases.
    run_burst(4'b1001, 6, 0, 1'b0);
    run_burst(4'b1001, 12, 0, 1'b0);
    run_burst(4'b0001, 8, 0, 1'b0);
    run_burst(4'b0101, 0, 0, 1'b0);
    run_burst(4'b1001, 20, 5, 1'b0);
    run_burst(4'b1001, 16, 0, 1'b0);

    // abort together with start in IDLE: start ignored.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    seed  = 4'b1001;
    len   = LEN_W'(4);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort+start idle busy", 32'(busy), 0);
    @(negedge clk);
    check("abort+start idle busy2", 32'(busy), 0);

    // Asynchronous reset mid-burst (after the generator has hit 0000).
    @(negedge clk);
    start = 1'b1;
    seed  = 4'b0001;
    len   = LEN_W'(20);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre-rst busy", 32'(busy), 1);
    check("pre-rst err_stuck", 32'(err_stuck), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst busy", 32'(busy), 0);
    check("mid rst bit_valid", 32'(bit_valid), 0);
    check("mid rst bit_out", 32'(bit_out), 0);
    check("mid rst word_valid", 32'(word_valid), 0);
    check("mid rst word_out", 32'(word_out), 0);
    check("mid rst done", 32'(done), 0);
    check("mid rst err_stuck", 32'(err_stuck), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh burst with start/seed/len toggled while busy.
    run_burst(4'b1001, 20, 0, 1'b1);
    run_burst(4'b0110, 255, 0, 1'b1);

    // Randomized bursts.
    for (int k = 0; k < 40; k++) begin
      ln = $urandom_range(0, 40);
      ab = 0;
      if (ln > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, ln);
      run_burst(4'($urandom), ln, ab, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
